mem_wb_stage: RTL and testbench

Memory-access stage plus MEM/WB pipeline register of the 5-stage ARM datapath. Takes the EX/MEM bundle, performs load/store through a request/acknowledge word-memory port, and stalls the upstream pipeline with `freeze` while an access is outstanding. Drives `Dest_WB`, `Result_WB` and `writeBackEN` directly into the register file, which writes on the falling edge of the same clock.

---
 rtl/mem_wb_stage.sv | 116 +++++++++++
 tb/tb_mem_wb_stage.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_wb_stage.sv
// Memory-access stage and MEM/WB pipeline register: issues load/store requests on a
// req/ack word port, stalls upstream with freeze, and feeds the register-file write port.
module mem_wb_stage #(
  parameter logic [31:0] BASE_ADDR   = 32'd1024,
  parameter int          ADDR_W      = 16,
  parameter int          ACK_TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_en_in,
  input  logic              mem_r_en,
  input  logic              mem_w_en,
  input  logic [31:0]       alu_result,
  input  logic [31:0]       st_val,
  input  logic [3:0]        dest_in,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ack,
  output logic              freeze,
  output logic              mem_err,
  output logic              writeBackEN,
  output logic [3:0]        Dest_WB,
  output logic [31:0]       Result_WB
);

  localparam int              CNT_W    = $clog2(ACK_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t            state, state_n;
  logic [CNT_W-1:0]  cnt;
  logic              access, store, abort;
  logic [ADDR_W-1:0] word_addr;
  logic              wb_load;
  logic              wb_en_n;
  logic [31:0]       result_n;

  // A store wins when both enables are set, so store suppresses the load writeback.
  assign access    = mem_r_en | mem_w_en;
  assign store     = mem_w_en;
  assign word_addr = ADDR_W'((alu_result - BASE_ADDR) >> 2);
  assign abort     = (state == ACCESS) && !mem_ack && (cnt == CNT_LAST);

  always_comb begin
    // NOTE: every output of this block gets a default first so no path infers a latch.
    state_n  = state;
    freeze   = 1'b0;
    mem_err  = 1'b0;
    wb_load  = 1'b0;
    wb_en_n  = 1'b0;
    result_n = alu_result;
    case (state)
      IDLE: begin
        if (access) begin
          freeze  = 1'b1;
          state_n = ACCESS;
        end else begin
          wb_load = 1'b1;
          wb_en_n = wb_en_in;
        end
      end
      ACCESS: begin
        if (mem_ack) begin
          state_n  = IDLE;
          wb_load  = 1'b1;
          wb_en_n  = wb_en_in & ~store;
          result_n = store ? alu_result : mem_rdata;
        end else if (abort) begin
          state_n = IDLE;
          mem_err = 1'b1;
        end else begin
          freeze = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      writeBackEN <= 1'b0;
      Dest_WB     <= '0;
      Result_WB   <= '0;
    end else begin
      state       <= state_n;
      writeBackEN <= wb_en_n;
      if (wb_load) begin
        Dest_WB   <= dest_in;
        Result_WB <= result_n;
      end
      if (state == IDLE && access) begin
        mem_req   <= 1'b1;
        mem_we    <= store;
        mem_addr  <= word_addr;
        mem_wdata <= st_val;
        cnt       <= '0;
      end else if (state == ACCESS) begin
        // Request fields stay frozen until the access completes or is aborted.
        if (mem_ack || abort) mem_req <= 1'b0;
        else                  cnt     <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: a memory responder with programmable wait,
// a writeback scoreboard, and per-scenario tasks.
module tb_mem_wb_stage;

  localparam int ADDR_W = 16;

  logic              clk, rst;
  logic              wb_en_in, mem_r_en, mem_w_en;
  logic [31:0]       alu_result, st_val;
  logic [3:0]        dest_in;
  logic              mem_req, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata, mem_rdata;
  logic              mem_ack, freeze, mem_err, writeBackEN;
  logic [3:0]        Dest_WB;
  logic [31:0]       Result_WB;

  mem_wb_stage #(.BASE_ADDR(32'd1024), .ADDR_W(ADDR_W), .ACK_TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .wb_en_in(wb_en_in), .mem_r_en(mem_r_en), .mem_w_en(mem_w_en),
    .alu_result(alu_result), .st_val(st_val), .dest_in(dest_in),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .freeze(freeze), .mem_err(mem_err),
    .writeBackEN(writeBackEN), .Dest_WB(Dest_WB), .Result_WB(Result_WB)
  );

  typedef struct packed {
    logic [3:0]  dest;
    logic [31:0] result;
  } wb_t;

  wb_t         exp_q[$];
  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] mem_img [16];
  int          ack_wait = 0;
  logic        ack_en   = 1'b1;
  logic        late_ack = 1'b0;
  int          req_cycles = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory responder: acks ack_wait cycles after mem_req rises, models word storage.
  always begin
    @(posedge clk);
    #1;
    if (mem_req) begin
      if (ack_en && req_cycles == ack_wait) begin
        mem_ack   = 1'b1;
        mem_rdata = mem_img[mem_addr[3:0]];
        if (mem_we) mem_img[mem_addr[3:0]] = mem_wdata;
      end else begin
        mem_ack   = 1'b0;
        mem_rdata = 32'h0;
      end
      req_cycles++;
    end else begin
      req_cycles = 0;
      mem_ack    = late_ack;
      mem_rdata  = late_ack ? 32'hBAD0_BAD0 : 32'h0;
    end
  end

  // Scoreboard: every cycle with writeBackEN must match the oldest expected retirement.
  always @(negedge clk) begin
    if (!rst && writeBackEN) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_errors++;
        $display("FAIL wb_unexpected: got dest=%0d result=%h, expected no writeback", Dest_WB, Result_WB);
      end else begin
        wb_t e;
        e = exp_q.pop_front();
        if ({Dest_WB, Result_WB} !== e) begin
          n_errors++;
          $display("FAIL wb_data: got dest=%0d result=%h, expected dest=%0d result=%h",
                   Dest_WB, Result_WB, e.dest, e.result);
        end
      end
    end
  end

  task automatic drive(input logic wb, r, w, input logic [31:0] a, sv, input logic [3:0] d);
    wb_en_in = wb; mem_r_en = r; mem_w_en = w; alu_result = a; st_val = sv; dest_in = d;
  endtask

  task automatic nop();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
  endtask

  task automatic err(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_errors++;
    $display("FAIL %s: got %h, expected %h", name, got, exp);
  endtask

  // Presents one memory instruction and follows it until freeze drops; returns just
  // after the edge that loads the WB register, with the inputs still presented.
  task automatic do_access(input string name, input logic wb, r, w, input logic [31:0] a, sv,
                           input logic [3:0] d, input int w_ack, input logic en,
                           input int exp_fr, input int exp_req, input logic exp_abort);
    logic [31:0] off;
    logic [15:0] exp_addr;
    int fr, reqc, errc;
    bit seen, done;
    off = a - 32'd1024;
    exp_addr = off[17:2];
    ack_wait = w_ack;
    ack_en = en;
    drive(wb, r, w, a, sv, d);
    if (wb && r && !w && !exp_abort) exp_q.push_back({d, mem_img[exp_addr[3:0]]});
    fr = 0; reqc = 0; errc = 0; seen = 0; done = 0;
    @(negedge clk);
    n_checks++;
    if (mem_req !== 1'b0) err({name, "_idle_req"}, 32'(mem_req), 32'h0);
    for (int i = 0; i < 100 && !done; i++) begin
      if (i > 0) @(negedge clk);
      if (mem_req) begin
        reqc++;
        if (!seen) begin
          seen = 1;
          n_checks += 2;
          if (mem_addr !== exp_addr) err({name, "_addr"}, 32'(mem_addr), 32'(exp_addr));
          if (mem_we !== w) err({name, "_we"}, 32'(mem_we), 32'(w));
          if (w) begin
            n_checks++;
            if (mem_wdata !== sv) err({name, "_wdata"}, mem_wdata, sv);
          end
        end
      end
      if (mem_err) errc++;
      if (!freeze) done = 1;
      else fr++;
    end
    n_checks += 4;
    if (!done) err({name, "_stall_bound"}, 32'(fr), 32'(exp_fr));
    if (fr != exp_fr) err({name, "_freeze_cycles"}, 32'(fr), 32'(exp_fr));
    if (reqc != exp_req) err({name, "_req_cycles"}, 32'(reqc), 32'(exp_req));
    if (errc != int'(exp_abort)) err({name, "_mem_err"}, 32'(errc), 32'(exp_abort));
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_checks += 9;
    if (mem_req !== 1'b0)     err("rst_mem_req", 32'(mem_req), 32'h0);
    if (mem_we !== 1'b0)      err("rst_mem_we", 32'(mem_we), 32'h0);
    if (mem_addr !== '0)      err("rst_mem_addr", 32'(mem_addr), 32'h0);
    if (mem_wdata !== '0)     err("rst_mem_wdata", mem_wdata, 32'h0);
    if (writeBackEN !== 1'b0) err("rst_wb_en", 32'(writeBackEN), 32'h0);
    if (Dest_WB !== '0)       err("rst_dest", 32'(Dest_WB), 32'h0);
    if (Result_WB !== '0)     err("rst_result", Result_WB, 32'h0);
    if (mem_err !== 1'b0)     err("rst_mem_err", 32'(mem_err), 32'h0);
    if (freeze !== 1'b0)      err("rst_freeze", 32'(freeze), 32'h0);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_non_mem();
    drive(1'b1, 1'b0, 1'b0, 32'h1234, 32'h0, 4'd5);
    exp_q.push_back({4'd5, 32'h1234});
    @(negedge clk);
    n_checks++;
    if (freeze !== 1'b0) err("nonmem_freeze", 32'(freeze), 32'h0);
    @(posedge clk);
    #1;
    nop();
    @(negedge clk);
    n_checks++;
    if (writeBackEN !== 1'b1) err("nonmem_latency", 32'(writeBackEN), 32'h1);
    @(posedge clk);
    #1;
  endtask

  task automatic test_load();
    do_access("load", 1'b1, 1'b1, 1'b0, 32'd1032, 32'h0, 4'd3, 3, 1'b1, 4, 4, 1'b0);
    nop();
    @(negedge clk);
    n_checks++;
    if (writeBackEN !== 1'b1) err("load_wb_en", 32'(writeBackEN), 32'h1);
    @(posedge clk);
    #1;
  endtask

  task automatic test_store();
    do_access("store", 1'b1, 1'b0, 1'b1, 32'd1028, 32'hA5A5_A5A5, 4'd7, 0, 1'b1, 1, 1, 1'b0);
    nop();
    @(negedge clk);
    n_checks += 2;
    if (writeBackEN !== 1'b0) err("store_wb_en", 32'(writeBackEN), 32'h0);
    if (mem_img[1] !== 32'hA5A5_A5A5) err("store_mem_word", mem_img[1], 32'hA5A5_A5A5);
    @(posedge clk);
    #1;
  endtask

  task automatic test_back_to_back();
    do_access("b2b_first", 1'b1, 1'b1, 1'b0, 32'd1024, 32'h0, 4'd8, 1, 1'b1, 2, 2, 1'b0);
    do_access("b2b_second", 1'b1, 1'b1, 1'b0, 32'd1028, 32'h0, 4'd9, 0, 1'b1, 1, 1, 1'b0);
    nop();
    @(negedge clk);
    n_checks++;
    if (Result_WB !== 32'hA5A5_A5A5) err("b2b_second_result", Result_WB, 32'hA5A5_A5A5);
    @(posedge clk);
    #1;
  endtask

  task automatic test_timeout();
    do_access("timeout", 1'b1, 1'b1, 1'b0, 32'd1044, 32'h0, 4'd2, 0, 1'b0, 4, 4, 1'b1);
    nop();
    late_ack = 1'b1;
    @(negedge clk);
    n_checks += 3;
    if (mem_req !== 1'b0)     err("timeout_req_drop", 32'(mem_req), 32'h0);
    if (writeBackEN !== 1'b0) err("timeout_wb_en", 32'(writeBackEN), 32'h0);
    if (freeze !== 1'b0)      err("timeout_freeze", 32'(freeze), 32'h0);
    @(posedge clk);
    #1;
    @(negedge clk);
    n_checks += 2;
    if (mem_req !== 1'b0)     err("late_ack_req", 32'(mem_req), 32'h0);
    if (writeBackEN !== 1'b0) err("late_ack_wb_en", 32'(writeBackEN), 32'h0);
    late_ack = 1'b0;
    ack_en = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_in_access();
    ack_en = 1'b0;
    drive(1'b1, 1'b1, 1'b0, 32'd1036, 32'h0, 4'd6);
    repeat (2) @(negedge clk);
    n_checks++;
    if (mem_req !== 1'b1) err("rstacc_req_before", 32'(mem_req), 32'h1);
    #2 rst = 1'b1;
    #1;
    n_checks += 4;
    if (mem_req !== 1'b0)     err("rstacc_req", 32'(mem_req), 32'h0);
    if (writeBackEN !== 1'b0) err("rstacc_wb_en", 32'(writeBackEN), 32'h0);
    if (Result_WB !== '0)     err("rstacc_result", Result_WB, 32'h0);
    if (freeze !== 1'b1)      err("rstacc_freeze_access", 32'(freeze), 32'h1);
    @(posedge clk);
    #1;
    nop();
    @(negedge clk);
    n_checks++;
    if (freeze !== 1'b0) err("rstacc_freeze_idle", 32'(freeze), 32'h0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    do_access("post_rst_load", 1'b1, 1'b1, 1'b0, 32'd1040, 32'h0, 4'd4, 2, 1'b1, 3, 3, 1'b0);
    nop();
    @(negedge clk);
    n_checks++;
    if (writeBackEN !== 1'b1) err("post_rst_wb_en", 32'(writeBackEN), 32'h1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem_img[i] = 32'h1000_0000 + 32'(i);
    mem_img[2] = 32'hDEAD_BEEF;
    mem_ack = 1'b0;
    mem_rdata = 32'h0;
    rst = 1'b1;
    nop();
    test_reset();
    test_non_mem();
    test_load();
    test_store();
    test_back_to_back();
    test_timeout();
    test_reset_in_access();
    repeat (2) @(negedge clk);
    n_checks++;
    if (exp_q.size() != 0) err("wb_missing", 32'(exp_q.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
